i2c_regdec: RTL and testbench

- Byte-level command decoder directly downstream of the flasher's I2C slave byte engine.
- Consumes received bytes of form {tag[1:0], payload[5:0]}.
  - Tag A_ADDR selects a register.
  - Tag D_ADDR writes the selected register.
- Holds the small register file that drives LED mode/rate in the flasher.
- Serves read bytes back to the slave on request.

---
 rtl/i2c_regdec_pkg.sv | 34 +++
 rtl/i2c_regdec_regfile.sv | 50 +++++
 rtl/i2c_regdec.sv | 141 ++++++++++++++
 tb/tb_i2c_regdec.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_regdec_pkg.sv
// Shared tags, register indices and FSM encoding for the I2C register decoder.
package i2c_regdec_pkg;

  localparam logic [1:0] A_ADDR = 2'b00;
  localparam logic [1:0] D_ADDR = 2'b01;
  localparam int I2C_DATA_BITS = 6;

  localparam int R_ID      = 0;
  localparam int R_SCRATCH = 1;
  localparam int R_LEDMODE = 2;
  localparam int R_LEDRATE = 3;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_OPEN_NOADDR = 2'd1,
    ST_OPEN_ADDR   = 2'd2
  } state_e;

  // Reset contents of register idx; register 0 holds the read-only ID.
  function automatic logic [I2C_DATA_BITS-1:0] reg_rst_val(
    input int idx,
    input logic [I2C_DATA_BITS-1:0] id_val,
    input logic [I2C_DATA_BITS-1:0] mode_val,
    input logic [I2C_DATA_BITS-1:0] rate_val
  );
    case (idx)
      R_ID:      return id_val;
      R_LEDMODE: return mode_val;
      R_LEDRATE: return rate_val;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_regdec_regfile.sv
// NREGS x 6-bit register storage with read mux; register 0 is a constant ID.
module i2c_regdec_regfile
  import i2c_regdec_pkg::*;
#(
  parameter int NREGS = 4,
  parameter logic [5:0] ID_VAL   = 6'h2A,
  parameter logic [5:0] RST_MODE = 6'd0,
  parameter logic [5:0] RST_RATE = 6'd8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [5:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [5:0]    rd_data_o,
  output logic [5:0]    led_mode_o,
  output logic [5:0]    led_rate_o
);

  logic [I2C_DATA_BITS-1:0] mem_q [NREGS];

  // Storage: entry 0 is loaded with the ID at reset and never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= reg_rst_val(i, ID_VAL, RST_MODE, RST_RATE);
      end
    end else if (wr_en_i && (wr_addr_i != '0)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

  // Small register files without LED registers fall back to the reset values.
  if (NREGS > R_LEDMODE) begin : g_mode
    assign led_mode_o = mem_q[R_LEDMODE];
  end else begin : g_mode_const
    assign led_mode_o = RST_MODE;
  end

  if (NREGS > R_LEDRATE) begin : g_rate
    assign led_rate_o = mem_q[R_LEDRATE];
  end else begin : g_rate_const
    assign led_rate_o = RST_RATE;
  end

endmodule

// File: rtl/i2c_regdec.sv
// Byte-level command decoder behind the I2C slave byte engine.
// Optional macro REGDEC_AUTOINC_EN: pointer auto-increments after each
// D_ADDR write (including dropped register-0 writes) and each served read.
module i2c_regdec
  import i2c_regdec_pkg::*;
#(
  parameter int NREGS = 4,
  parameter logic [5:0] ID_VAL   = 6'h2A,
  parameter logic [5:0] RST_MODE = 6'd0,
  parameter logic [5:0] RST_RATE = 6'd8
) (
  input  logic                     clk,
  input  logic                     GSRn,
  input  logic                     rx_start,
  input  logic                     rx_stop,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     tx_req,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  output logic                     reg_wr,
  output logic [$clog2(NREGS)-1:0] reg_addr,
  output logic [5:0]               reg_wdata,
  output logic [5:0]               led_mode,
  output logic [5:0]               led_rate,
  output logic                     busy,
  output logic [7:0]               err_cnt
);

  localparam int AW = $clog2(NREGS);
  localparam logic [6:0] NREGS_W = 7'(NREGS);

  state_e        state_q, state_d;
  logic          has_addr_q, has_addr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    err_q, err_d;
  logic          busy_q, reg_wr_q, tx_valid_q;
  logic [5:0]    wdata_q;
  logic [7:0]    tx_data_q;

  logic [1:0] tag;
  logic [5:0] payload;
  logic [5:0] rd_data;
  logic       byte_en, addr_ok, data_hit, wr_en, byte_err, tx_ok, tx_err;
  logic [8:0] err_sum;

  assign tag     = rx_data[7:6];
  assign payload = rx_data[5:0];

`ifdef REGDEC_AUTOINC_EN
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction
`endif

  // Byte/read decode and next-state computation; a start on the same cycle
  // masks the byte, a stop is applied after the byte.
  always_comb begin
    byte_en  = rx_valid && (state_q != ST_IDLE) && !rx_start;
    addr_ok  = byte_en && (tag == A_ADDR) && ({1'b0, payload} < NREGS_W);
    data_hit = byte_en && (tag == D_ADDR) && (state_q == ST_OPEN_ADDR);
    wr_en    = data_hit && (addr_q != '0);
    byte_err = byte_en && !addr_ok && !wr_en;
    tx_ok    = tx_req && (state_q == ST_OPEN_ADDR);
    tx_err   = tx_req && !tx_ok;

    addr_d = addr_q;
`ifdef REGDEC_AUTOINC_EN
    if (data_hit) addr_d = wrap_inc(addr_d);
    if (tx_ok)    addr_d = wrap_inc(addr_d);
`endif
    if (addr_ok) addr_d = payload[AW-1:0];

    has_addr_d = has_addr_q | addr_ok;

    err_sum = {1'b0, err_q} + {8'd0, byte_err} + {8'd0, tx_err};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rx_start) state_d = ST_OPEN_NOADDR;
      default: begin
        if (rx_stop)       state_d = ST_IDLE;
        else if (rx_start) state_d = has_addr_q ? ST_OPEN_ADDR : ST_OPEN_NOADDR;
        else if (addr_ok)  state_d = ST_OPEN_ADDR;
      end
    endcase
  end

  // FSM state, pointer, error counter and all registered outputs.
  always_ff @(posedge clk or negedge GSRn) begin
    if (!GSRn) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      has_addr_q <= 1'b0;
      addr_q     <= '0;
      err_q      <= '0;
      reg_wr_q   <= 1'b0;
      wdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != ST_IDLE);
      has_addr_q <= has_addr_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      reg_wr_q   <= wr_en;
      if (wr_en) wdata_q <= payload;
      tx_valid_q <= tx_req;
      if (tx_req) tx_data_q <= tx_ok ? {2'b01, rd_data} : 8'hFF;
    end
  end

  i2c_regdec_regfile #(
    .NREGS   (NREGS),
    .ID_VAL  (ID_VAL),
    .RST_MODE(RST_MODE),
    .RST_RATE(RST_RATE)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (GSRn),
    .wr_en_i   (wr_en),
    .wr_addr_i (addr_q),
    .wr_data_i (payload),
    .rd_addr_i (addr_q),
    .rd_data_o (rd_data),
    .led_mode_o(led_mode),
    .led_rate_o(led_rate)
  );

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign reg_wr    = reg_wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = busy_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_i2c_regdec.sv
// Directed and randomized bench for i2c_regdec against a behavioural model.
module tb_i2c_regdec;

  localparam int NREGS = 4;
  localparam logic [5:0] ID_VAL   = 6'h2A;
  localparam logic [5:0] RST_MODE = 6'd0;
  localparam logic [5:0] RST_RATE = 6'd8;

  logic       clk = 1'b0;
  logic       GSRn = 1'b0;
  logic       rx_start = 1'b0, rx_stop = 1'b0, rx_valid = 1'b0, tx_req = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_valid, reg_wr, busy;
  logic [7:0] tx_data, err_cnt;
  logic [1:0] reg_addr;
  logic [5:0] reg_wdata, led_mode, led_rate;

  always #5 clk = ~clk;

  i2c_regdec #(
    .NREGS(NREGS), .ID_VAL(ID_VAL), .RST_MODE(RST_MODE), .RST_RATE(RST_RATE)
  ) dut (
    .clk(clk), .GSRn(GSRn), .rx_start(rx_start), .rx_stop(rx_stop),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req),
    .tx_valid(tx_valid), .tx_data(tx_data), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .led_mode(led_mode),
    .led_rate(led_rate), .busy(busy), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: transaction open flag, "address known in this
  // transaction" flag, "address ever set" flag, pointer, register array.
  bit         m_open, m_addrd, m_ever, m_txv, m_wr;
  int         m_ptr;
  logic [5:0] m_reg [NREGS];
  logic [5:0] m_wdata;
  logic [7:0] m_txd, m_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_addrd = 0; m_ever = 0; m_txv = 0; m_wr = 0; m_ptr = 0;
    m_reg[0] = ID_VAL; m_reg[1] = 6'd0; m_reg[2] = RST_MODE; m_reg[3] = RST_RATE;
    m_wdata = 6'd0; m_txd = 8'h00; m_err = 8'h00;
  endtask

  task automatic model_step(input bit s, input bit p, input bit v,
                            input logic [7:0] d, input bit t);
    int ptr0, nerr, incs, e;
    bit load;
    ptr0 = m_ptr; nerr = 0; incs = 0; load = 0;
    m_txv = t; m_wr = 0;
    if (t) begin
      if (m_open && m_addrd) begin
        m_txd = {2'b01, m_reg[ptr0]};
        incs++;
      end else begin
        m_txd = 8'hFF;
        nerr++;
      end
    end
    if (v && m_open && !s) begin
      case (d[7:6])
        2'b00: begin
          if (int'(d[5:0]) < NREGS) begin
            load = 1; m_addrd = 1; m_ever = 1;
          end else nerr++;
        end
        2'b01: begin
          if (!m_addrd) nerr++;
          else begin
            incs++;
            if (ptr0 == 0) nerr++;
            else begin
              m_reg[ptr0] = d[5:0];
              m_wdata = d[5:0];
              m_wr = 1;
            end
          end
        end
        default: nerr++;
      endcase
    end
    if (m_open) begin
      if (p) m_open = 0;
      else if (s) m_addrd = m_ever;
    end else if (s) begin
      m_open = 1; m_addrd = 0;
    end
`ifndef REGDEC_AUTOINC_EN
    incs = 0;
`endif
    m_ptr = load ? int'(d[5:0]) : (ptr0 + incs) % NREGS;
    e = int'(m_err) + nerr;
    m_err = (e > 255) ? 8'hFF : 8'(e);
  endtask

  task automatic check_all();
    chk("tx_valid", {7'd0, tx_valid}, {7'd0, m_txv});
    chk("tx_data", tx_data, m_txd);
    chk("reg_wr", {7'd0, reg_wr}, {7'd0, m_wr});
    chk("reg_addr", {6'd0, reg_addr}, 8'(m_ptr));
    chk("reg_wdata", {2'b0, reg_wdata}, {2'b0, m_wdata});
    chk("led_mode", {2'b0, led_mode}, {2'b0, m_reg[2]});
    chk("led_rate", {2'b0, led_rate}, {2'b0, m_reg[3]});
    chk("busy", {7'd0, busy}, {7'd0, m_open});
    chk("err_cnt", err_cnt, m_err);
  endtask

  task automatic step(input bit s, input bit p, input bit v,
                      input logic [7:0] d, input bit t);
    @(negedge clk);
    rx_start = s; rx_stop = p; rx_valid = v; rx_data = d; tx_req = t;
    @(posedge clk);
    model_step(s, p, v, d, t);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 0);
  endtask

  task automatic wbyte(input logic [7:0] d);
    step(0, 0, 1, d, 0);
  endtask

  // Asynchronous reset pulse while the clock is low.
  task automatic do_reset();
    @(negedge clk);
    rx_start = 0; rx_stop = 0; rx_valid = 0; rx_data = 8'h00; tx_req = 0;
    #1 GSRn = 1'b0;
    model_reset();
    #1;
    check_all();
    #1 GSRn = 1'b1;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_led_rate", {2'b0, led_rate}, 8'h08);
    chk("rst_busy", {7'd0, busy}, 8'h00);

    // Plain write to LED mode
    step(1, 0, 0, 8'h00, 0);
    wbyte(8'h02);
    wbyte(8'h41);
    chk("w1_reg_wr", {7'd0, reg_wr}, 8'h01);
    chk("w1_wdata", {2'b0, reg_wdata}, 8'h01);
    chk("w1_led_mode", {2'b0, led_mode}, 8'h01);
    step(0, 1, 0, 8'h00, 0);
    idle();
    chk("w1_busy_after_stop", {7'd0, busy}, 8'h00);
    chk("w1_err", err_cnt, 8'h00);

    // Data byte without address, then read, bad address, register 0 write
    do_reset();
    step(1, 0, 0, 8'h00, 0);
    wbyte(8'h41);
    chk("noaddr_err", err_cnt, 8'h01);
    chk("noaddr_reg_wr", {7'd0, reg_wr}, 8'h00);
    chk("noaddr_led_mode", {2'b0, led_mode}, {2'b0, RST_MODE});
    wbyte(8'h03);
    step(0, 0, 0, 8'h00, 1);
    chk("rd_rate_valid", {7'd0, tx_valid}, 8'h01);
    chk("rd_rate_data", tx_data, 8'h48);
    wbyte(8'h3F);
    chk("badaddr_err", err_cnt, 8'h02);
`ifndef REGDEC_AUTOINC_EN
    chk("badaddr_ptr", {6'd0, reg_addr}, 8'h03);
`endif
    wbyte(8'h00);
    wbyte(8'h55);
    chk("r0_wr_dropped", {7'd0, reg_wr}, 8'h00);
    chk("r0_err", err_cnt, 8'h03);
    step(0, 0, 0, 8'h00, 1);
`ifndef REGDEC_AUTOINC_EN
    chk("r0_readback", tx_data, 8'h6A);
`endif
    // Read outside an addressed transaction
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);
    chk("idle_read_data", tx_data, 8'hFF);
    chk("idle_read_err", err_cnt, 8'h04);

    // Simultaneous write + read returns pre-write value; write + stop
    step(1, 0, 0, 8'h00, 0);
    wbyte(8'h01);
    step(0, 0, 1, 8'h59, 1);
    chk("wr_rd_pre", tx_data, 8'h40);
    step(0, 1, 1, 8'h02, 0);
    chk("byte_with_stop_busy", {7'd0, busy}, 8'h00);

`ifdef REGDEC_AUTOINC_EN
    do_reset();
    step(1, 0, 0, 8'h00, 0);
    wbyte(8'h01);
    wbyte(8'h45);
    wbyte(8'h46);
    wbyte(8'h47);
    chk("ai_led_mode", {2'b0, led_mode}, 8'h06);
    chk("ai_led_rate", {2'b0, led_rate}, 8'h07);
    chk("ai_wrap", {6'd0, reg_addr}, 8'h00);
    wbyte(8'h01);
    step(0, 0, 0, 8'h00, 1);
    chk("ai_reg1", tx_data, 8'h45);
`endif

    // Reset in the middle of a transaction
    do_reset();
    step(1, 0, 0, 8'h00, 0);
    wbyte(8'h02);
    do_reset();
    step(1, 0, 0, 8'h00, 0);
    wbyte(8'h41);
    chk("midrst_err", err_cnt, 8'h01);
    chk("midrst_led_mode", {2'b0, led_mode}, {2'b0, RST_MODE});

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) wbyte(8'hC0);
    chk("err_saturate", err_cnt, 8'hFF);
    step(0, 1, 0, 8'h00, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      bit s, p, v, t;
      logic [7:0] d;
      if ((i % 250) == 0) do_reset();
      s = ($urandom_range(0, 99) < 8);
      p = ($urandom_range(0, 99) < 6);
      v = ($urandom_range(0, 99) < 45);
      t = ($urandom_range(0, 99) < 20);
      d[7:6] = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      d[5:0] = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 4)) : 6'($urandom);
      step(s, p, v, d, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
